// File: rtl/instr_fetch_queue.sv
// Instruction prefetch stage: issues one imem read per cycle and buffers
// returned instructions with their PCs in a FIFO toward decode.
module instr_fetch_queue #(
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [15:0]             imem_rdata,
  input  logic                    redirect_valid,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_instr,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = 16;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count_q;
  logic [IW-1:0]       instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [CW:0] occupancy_c;
  logic        issue_c;
  logic        push_c;
  logic        pop_c;

  // The in-flight read reserves a slot so a returning response always fits.
  assign occupancy_c = {1'b0, count_q} + (CW+1)'(inflight);
  assign issue_c     = !rst && !redirect_valid && (occupancy_c < (CW+1)'(DEPTH));
  assign push_c      = inflight && !redirect_valid;
  assign pop_c       = out_valid && out_ready;

  assign imem_req  = issue_c;
  assign imem_addr = fetch_pc;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign count     = count_q;

  // Fetch PC, in-flight tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        fetch_pc    <= fetch_pc + PC_WIDTH'(1);
        inflight_pc <= fetch_pc;
      end
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  // A response landing in a full FIFO means the credit logic is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_c && !pop_c && count_q == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a per-cycle vector table plus a
// hand-written wrap sequence on a second instance with RESET_PC=FE.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       rv;
    logic [7:0] rpc;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_pc;
    logic [2:0] e_cnt;
  } vec_t;

  // DUT A: RESET_PC = 0
  logic        rst, rdy, rv;
  logic [7:0]  rpc;
  logic        req;
  logic [7:0]  addr;
  logic [15:0] rdata;
  logic        valid;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [2:0]  cnt;

  // DUT B: RESET_PC = FE
  logic        rst_b, rdy_b, rv_b;
  logic [7:0]  rpc_b;
  logic        req_b;
  logic [7:0]  addr_b;
  logic [15:0] rdata_b;
  logic        valid_b;
  logic [15:0] instr_b;
  logic [7:0]  pc_b;
  logic [2:0]  cnt_b;

  instr_fetch_queue #(.DEPTH(4), .PC_WIDTH(8), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_rdata(rdata),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(valid), .out_ready(rdy),
    .out_instr(instr), .out_pc(pc), .count(cnt)
  );

  instr_fetch_queue #(.DEPTH(4), .PC_WIDTH(8), .RESET_PC(8'hFE)) dut_b (
    .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b), .out_valid(valid_b), .out_ready(rdy_b),
    .out_instr(instr_b), .out_pc(pc_b), .count(cnt_b)
  );

  // Latency-1 instruction memory: mem[a] = A000 + a
  always @(posedge clk) begin
    rdata   <= 16'hA000 + 16'(addr);
    rdata_b <= 16'hA000 + 16'(addr_b);
  end

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic rd, input logic rvv, input logic [7:0] rp,
                             input logic eq, input logic [7:0] ea, input logic ev,
                             input logic [7:0] ep, input logic [2:0] ec);
    vec_t t;
    t.rst = r; t.rdy = rd; t.rv = rvv; t.rpc = rp;
    t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep; t.e_cnt = ec;
    return t;
  endfunction

  initial begin
    //                  rst rdy rv rpc     req addr   val pc     cnt
    // streaming from reset
    vecs.push_back(v(1, 1, 0, 8'h00,  0, 8'h00,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h00,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h01,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h02,  1, 8'h00, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h03,  1, 8'h01, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h04,  1, 8'h02, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h05,  1, 8'h03, 3'd1));
    // reset, then out_ready low: fill to 4 and stall
    vecs.push_back(v(1, 0, 0, 8'h00,  0, 8'h00,  1, 8'h04, 3'd1));
    vecs.push_back(v(0, 0, 0, 8'h00,  1, 8'h00,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 0, 0, 8'h00,  1, 8'h01,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 0, 0, 8'h00,  1, 8'h02,  1, 8'h00, 3'd1));
    vecs.push_back(v(0, 0, 0, 8'h00,  1, 8'h03,  1, 8'h00, 3'd2));
    vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00,  1, 8'h00, 3'd3));
    vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00,  1, 8'h00, 3'd4));
    vecs.push_back(v(0, 0, 0, 8'h00,  0, 8'h00,  1, 8'h00, 3'd4));
    // release out_ready: drain in order, fetch resumes at 4
    vecs.push_back(v(0, 1, 0, 8'h00,  0, 8'h00,  1, 8'h00, 3'd4));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h04,  1, 8'h01, 3'd3));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h05,  1, 8'h02, 3'd2));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h06,  1, 8'h03, 3'd2));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h07,  1, 8'h04, 3'd2));
    // build count=3 with a read in flight, then redirect to 40
    vecs.push_back(v(0, 0, 0, 8'h00,  1, 8'h08,  1, 8'h05, 3'd2));
    vecs.push_back(v(0, 0, 1, 8'h40,  0, 8'h00,  1, 8'h05, 3'd3));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h40,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h41,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h42,  1, 8'h40, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h43,  1, 8'h41, 3'd1));
    // redirect to 5, then redirect while popping pc 5
    vecs.push_back(v(0, 1, 1, 8'h05,  0, 8'h00,  1, 8'h42, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h05,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h06,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 1, 8'h20,  0, 8'h00,  1, 8'h05, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h20,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h21,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h22,  1, 8'h20, 3'd1));
    // redirect held two cycles: last pc wins
    vecs.push_back(v(0, 1, 1, 8'h80,  0, 8'h00,  1, 8'h21, 3'd1));
    vecs.push_back(v(0, 1, 1, 8'h90,  0, 8'h00,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h90,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h91,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h92,  1, 8'h90, 3'd1));
    // PC wrap through FF
    vecs.push_back(v(0, 1, 1, 8'hFE,  0, 8'h00,  1, 8'h91, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'hFE,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'hFF,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h00,  1, 8'hFE, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h01,  1, 8'hFF, 3'd1));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h02,  1, 8'h00, 3'd1));
    // reset mid-stream with count=2
    vecs.push_back(v(0, 0, 0, 8'h00,  1, 8'h03,  1, 8'h01, 3'd1));
    vecs.push_back(v(1, 0, 0, 8'h00,  0, 8'h00,  1, 8'h01, 3'd2));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h00,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h01,  0, 8'h00, 3'd0));
    vecs.push_back(v(0, 1, 0, 8'h00,  1, 8'h02,  1, 8'h00, 3'd1));

    rst = 1'b1; rdy = 1'b1; rv = 1'b0; rpc = '0;
    rst_b = 1'b1; rdy_b = 1'b1; rv_b = 1'b0; rpc_b = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; rdy = vecs[i].rdy; rv = vecs[i].rv; rpc = vecs[i].rpc;
      #1;
      check($sformatf("row%0d imem_req", i), 16'(req), 16'(vecs[i].e_req));
      if (vecs[i].e_req)
        check($sformatf("row%0d imem_addr", i), 16'(addr), 16'(vecs[i].e_addr));
      check($sformatf("row%0d out_valid", i), 16'(valid), 16'(vecs[i].e_valid));
      check($sformatf("row%0d count", i), 16'(cnt), 16'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        check($sformatf("row%0d out_pc", i), 16'(pc), 16'(vecs[i].e_pc));
        check($sformatf("row%0d out_instr", i), instr, 16'hA000 + 16'(vecs[i].e_pc));
      end
    end

    // RESET_PC=FE instance: addresses and PCs wrap FE, FF, 00, 01
    for (int j = 0; j < 6; j++) begin
      logic [7:0] ea;
      logic [7:0] ep;
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      ea = 8'hFE + 8'(j);
      ep = 8'hFE + 8'(j) - 8'd2;
      check($sformatf("wrap%0d imem_req", j), 16'(req_b), 16'h1);
      check($sformatf("wrap%0d imem_addr", j), 16'(addr_b), 16'(ea));
      check($sformatf("wrap%0d out_valid", j), 16'(valid_b), (j >= 2) ? 16'h1 : 16'h0);
      if (j >= 2) begin
        check($sformatf("wrap%0d out_pc", j), 16'(pc_b), 16'(ep));
        check($sformatf("wrap%0d out_instr", j), instr_b, 16'hA000 + 16'(ep));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
